// File: rtl/varredura_servo_if.sv
// Handshake bundle between the sweep sequencer, its controller and the ranging block.
interface varredura_servo_if;
    logic       ligar;
    logic       medida_pronta;
    logic [1:0] posicao;
    logic       medir;
    logic       fim_varredura;
    logic       timeout;
    logic       sentido;
    logic [2:0] db_estado;

    // Controller/ranging side: drives the run level and measurement-done pulse.
    modport master (
        output ligar,
        output medida_pronta,
        input  posicao,
        input  medir,
        input  fim_varredura,
        input  timeout,
        input  sentido,
        input  db_estado
    );

    // Sequencer side.
    modport slave (
        input  ligar,
        input  medida_pronta,
        output posicao,
        output medir,
        output fim_varredura,
        output timeout,
        output sentido,
        output db_estado
    );
endinterface

// File: rtl/varredura_servo.sv
// Servo sweep sequencer: steps 01->10->11->10->01..., settles, requests one
// measurement per position and waits for completion or timeout.
module varredura_servo #(
    parameter int unsigned T_ASSENTAMENTO = 25000000,
    parameter int unsigned T_TIMEOUT      = 50000000
) (
    input  logic                   clock,
    input  logic                   reset,
    varredura_servo_if.slave       bus
);

    localparam int unsigned T_MAX = (T_ASSENTAMENTO > T_TIMEOUT) ? T_ASSENTAMENTO : T_TIMEOUT;
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [2:0] INICIAL   = 3'b000;
    localparam logic [2:0] POSICIONA = 3'b001;
    localparam logic [2:0] MEDE      = 3'b010;
    localparam logic [2:0] ESPERA    = 3'b011;
    localparam logic [2:0] PROXIMA   = 3'b100;

    localparam logic [1:0] POS_DESL  = 2'b00;
    localparam logic [1:0] POS_BAIXA = 2'b01;
    localparam logic [1:0] POS_MEIO  = 2'b10;
    localparam logic [1:0] POS_ALTA  = 2'b11;

    localparam logic [CNT_W-1:0] FIM_ASSENT = CNT_W'(T_ASSENTAMENTO - 1);
    localparam logic [CNT_W-1:0] FIM_ESPERA = CNT_W'(T_TIMEOUT - 1);

    logic [2:0]       estado, estado_nxt;
    logic [CNT_W-1:0] cnt_assent, cnt_assent_nxt;
    logic [CNT_W-1:0] cnt_espera, cnt_espera_nxt;
    logic [1:0]       posicao_q, posicao_nxt;
    logic             sentido_q, sentido_nxt;
    logic             medir_q, medir_nxt;
    logic             fim_q, fim_nxt;
    logic             timeout_q, timeout_nxt;
    logic             no_extremo;

    // The current position is an end of travel for the current direction.
    assign no_extremo = (!sentido_q && (posicao_q == POS_ALTA)) ||
                        ( sentido_q && (posicao_q == POS_BAIXA));

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            cnt_assent <= '0;
            cnt_espera <= '0;
            posicao_q  <= POS_DESL;
            sentido_q  <= 1'b0;
            medir_q    <= 1'b0;
            fim_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            estado     <= estado_nxt;
            cnt_assent <= cnt_assent_nxt;
            cnt_espera <= cnt_espera_nxt;
            posicao_q  <= posicao_nxt;
            sentido_q  <= sentido_nxt;
            medir_q    <= medir_nxt;
            fim_q      <= fim_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    // Next state plus next value of every registered output; pulses are
    // decided on the edge entering the state in which they must be visible.
    always_comb begin
        estado_nxt     = estado;
        cnt_assent_nxt = '0;
        cnt_espera_nxt = '0;
        posicao_nxt    = posicao_q;
        sentido_nxt    = sentido_q;
        medir_nxt      = 1'b0;
        fim_nxt        = 1'b0;
        timeout_nxt    = 1'b0;

        case (estado)
            INICIAL: begin
                posicao_nxt = POS_DESL;
                sentido_nxt = 1'b0;
                if (bus.ligar) begin
                    estado_nxt  = POSICIONA;
                    posicao_nxt = POS_BAIXA;
                end
            end

            POSICIONA: begin
                if (cnt_assent == FIM_ASSENT) begin
                    estado_nxt = MEDE;
                    medir_nxt  = 1'b1;
                end else begin
                    cnt_assent_nxt = cnt_assent + CNT_W'(1);
                end
            end

            MEDE: begin
                estado_nxt = ESPERA;
            end

            ESPERA: begin
                // A completed measurement takes priority over the timeout.
                if (bus.medida_pronta) begin
                    estado_nxt = PROXIMA;
                    fim_nxt    = no_extremo;
                end else if (cnt_espera == FIM_ESPERA) begin
                    estado_nxt  = PROXIMA;
                    timeout_nxt = 1'b1;
                    fim_nxt     = no_extremo;
                end else begin
                    cnt_espera_nxt = cnt_espera + CNT_W'(1);
                end
            end

            PROXIMA: begin
                if (!bus.ligar) begin
                    estado_nxt  = INICIAL;
                    posicao_nxt = POS_DESL;
                    sentido_nxt = 1'b0;
                end else begin
                    estado_nxt = POSICIONA;
                    if (!sentido_q) begin
                        case (posicao_q)
                            POS_BAIXA: posicao_nxt = POS_MEIO;
                            POS_MEIO:  posicao_nxt = POS_ALTA;
                            POS_ALTA: begin
                                posicao_nxt = POS_MEIO;
                                sentido_nxt = 1'b1;
                            end
                            default:   posicao_nxt = POS_BAIXA;
                        endcase
                    end else begin
                        case (posicao_q)
                            POS_ALTA:  posicao_nxt = POS_MEIO;
                            POS_MEIO:  posicao_nxt = POS_BAIXA;
                            POS_BAIXA: begin
                                posicao_nxt = POS_MEIO;
                                sentido_nxt = 1'b0;
                            end
                            default:   posicao_nxt = POS_BAIXA;
                        endcase
                    end
                end
            end

            default: begin
                estado_nxt  = INICIAL;
                posicao_nxt = POS_DESL;
                sentido_nxt = 1'b0;
            end
        endcase
    end

    // Drive the bus from the output registers.
    assign bus.posicao       = posicao_q;
    assign bus.sentido       = sentido_q;
    assign bus.medir         = medir_q;
    assign bus.fim_varredura = fim_q;
    assign bus.timeout       = timeout_q;
    assign bus.db_estado     = estado;

endmodule

// File: doc/varredura_servo.md
# varredura_servo

Sweep sequencer for the hobby-servo PWM controller. It steps the 2-bit position code through the three powered angles (01 → 10 → 11 → 10 → 01 …). At each angle it waits a mechanical settle time, then requests one measurement from the ranging block and waits for completion or a timeout before moving on. Its `posicao` output drives the servo controller's `posicao` input directly; the code 00 (zero-width pulse, servo unpowered) is used only while idle.

## Interface

- `T_ASSENTAMENTO`, default 25000000: settle cycles spent at each position before measuring (500 ms at 50 MHz).
- `T_TIMEOUT`, default 50000000: maximum cycles spent waiting for `medida_pronta`.
- `clock`  in  1  system clock (50 MHz); the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ligar`  in  1  level; 1 = run the sweep, 0 = park the servo after the current measurement.
- `medida_pronta`  in  1  one-cycle pulse from the ranging block when a measurement completes.
- `posicao`  out  2  position code to the servo controller.
- `medir`  out  1  one-cycle measurement request.
- `fim_varredura`  out  1  one-cycle pulse when the sweep reverses at either end.
- `timeout`  out  1  one-cycle pulse when a measurement wait expires.
- `sentido`  out  1  sweep direction: 0 = increasing, 1 = decreasing.
- `db_estado`  out  3  current state encoding, for debug.

## Operation

- All outputs are registered, Moore style.
- Five-state FSM:
  - INICIAL = 000
  - POSICIONA = 001
  - MEDE = 010
  - ESPERA = 011
  - PROXIMA = 100
- INICIAL: `posicao`=00, `sentido`=0.
  - If `ligar`=1, go to POSICIONA with `posicao`=01.
  - Otherwise stay.
- POSICIONA: the settle counter starts at 0 on entry and increments each cycle.
  - At count = `T_ASSENTAMENTO`-1, go to MEDE.
- MEDE: `medir`=1 for this single cycle, then go to ESPERA.
- ESPERA: the timeout counter starts at 0 on entry.
  - `medida_pronta`=1 → go to PROXIMA.
  - Otherwise, at count = `T_TIMEOUT`-1 → go to PROXIMA and pulse `timeout` in the PROXIMA cycle.
  - If both happen in the same cycle, `medida_pronta` wins and there is no `timeout` pulse.
- PROXIMA (one cycle):
  - If `ligar`=0 → go to INICIAL; `posicao`=00 and `sentido`=0 from the next cycle.
  - Otherwise compute the next position:
    - `sentido`=0: 01→10, 10→11.
    - At 11 with `sentido`=0: set `sentido`=1, next position = 10, pulse `fim_varredura`.
    - `sentido`=1: 11→10, 10→01.
    - At 01 with `sentido`=1: set `sentido`=0, next position = 10, pulse `fim_varredura`.
    - Then go to POSICIONA.
- `posicao` never takes the value 00 outside INICIAL.
- `medida_pronta` is ignored in every state except ESPERA.
- `ligar` is sampled only in INICIAL and PROXIMA. Dropping it mid-settle or mid-wait still completes that position's measurement.
- Counter widths are $clog2 of the larger parameter, so no counter wraps before its terminal count.

## Timing

- Reset values: `posicao`=00, `medir`=0, `fim_varredura`=0, `timeout`=0, `sentido`=0, `db_estado`=000, both counters 0.
- Reset asserted in any state returns to INICIAL at the next edge and overrides all other inputs.
- From the `ligar`=1 sample in INICIAL:
  - `posicao`=01 appears 1 cycle later.
  - `medir` is high `T_ASSENTAMENTO`+1 cycles later.
- Per-position period, with `medida_pronta` arriving k cycles after the first ESPERA cycle (k ≥ 0): `T_ASSENTAMENTO` + 1 (MEDE) + (k+1) (ESPERA) + 1 (PROXIMA).
- With a timeout, the ESPERA term becomes `T_TIMEOUT`.
- `posicao` changes only on the PROXIMA→POSICIONA and PROXIMA/INICIAL transition edges. It is held stable for the entire settle-measure-wait interval.
- `fim_varredura` and `timeout` are each exactly 1 cycle wide and occur only in the PROXIMA cycle.

## Test plan

Bench settings: `T_ASSENTAMENTO`=10, `T_TIMEOUT`=20, ranging model answering 3 cycles after `medir`.

- **Reset:** assert `reset` mid-ESPERA → next cycle `posicao`=00, `db_estado`=000, all pulses 0; with `ligar`=1 held, the sweep restarts at 01.
- **Full sweep:** `ligar`=1 held for 8 positions →
  - `posicao` sequence 01,10,11,10,01,10,11,10.
  - `fim_varredura` pulses after 11 and after 01.
  - `sentido` toggles 0→1→0.
  - Exactly one `medir` per position, issued 10 cycles after each `posicao` change.
- **Handshake:** `medida_pronta` pulsed during POSICIONA and MEDE → ignored. The real pulse in ESPERA → PROXIMA the next cycle.
- **Timeout:** ranging model silent → ESPERA lasts 20 cycles, one `timeout` pulse, position advances; no pulse when the model answers on the final (20th) ESPERA cycle.
- **Stop:** drop `ligar` during POSICIONA at `posicao`=10 →
  - The measurement still occurs.
  - After PROXIMA, `posicao`=00 and the FSM rests in INICIAL.
  - Re-raising `ligar` restarts at 01 with `sentido`=0.
- **Boundary:** `medida_pronta` and timeout terminal count in the same cycle → no `timeout` pulse, normal advance.
